e_mdu_pipe: RTL

//  Parametrised multiply/divide unit for the execute stage, beside the single-cycle ALU.

---
 rtl/e_mdu_pipe_pkg.sv | 42 ++++
 rtl/e_mdu_arith.sv | 97 +++++++++
 rtl/e_mdu_pipe.sv | 117 +++++++++++
 3 files changed

// File: rtl/e_mdu_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : e_mdu_pipe_pkg
//  Purpose : Shared MDU operation encodings, default latencies and decode
//            helpers for the execute-stage multiply/divide unit.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package e_mdu_pipe_pkg;

  // 4-bit MDU operation codes carried on MDUOp.
  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8,
    MDU_MSUB  = 4'd9,
    MDU_MSUBU = 4'd10
  } mdu_op_e;

  localparam int c_MULT_CYCLES_DEF = 5;
  localparam int c_DIV_CYCLES_DEF  = 10;

  // Multiply-class ops: occupy the unit for MULT_CYCLES.
  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MDU_MULT)  || (op == MDU_MULTU) ||
           (op == MDU_MADD)  || (op == MDU_MADDU) ||
           (op == MDU_MSUB)  || (op == MDU_MSUBU);
  endfunction

  // Divide-class ops: occupy the unit for DIV_CYCLES.
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/e_mdu_arith.sv
`default_nettype none
// ============================================================================
//  Module  : e_mdu_arith
//  Purpose : Combinational result datapath of the MDU. Given the latched
//            op/operands and the current HI/LO it produces the values HI/LO
//            take on the completion edge.
//  Ports   : i_op       latched MDU operation
//            i_a, i_b   latched rs / rt operands
//            i_hi, i_lo current HI / LO (accumulate source)
//            o_next_hi  HI value to write
//            o_next_lo  LO value to write
//            o_we       write enable (low for divide by zero / non-arith op)
//  Rev     : 1.0  initial release
// ============================================================================
module e_mdu_arith
  import e_mdu_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  output logic [WIDTH-1:0] o_next_hi,
  output logic [WIDTH-1:0] o_next_lo,
  output logic             o_we
);

  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic [2*WIDTH-1:0] w_res;
  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_dvd;
  logic [WIDTH-1:0]   w_dvs;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_acc = {i_hi, i_lo};

  // Sign/zero-extend to 2*WIDTH so the low half of the product is exact
  // modulo 2^(2*WIDTH) for both signednesses.
  assign w_prod_s = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
  assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

  // One shared unsigned divider. Signed divide runs on magnitudes and fixes
  // signs afterwards; |MIN_INT| is representable as an unsigned WIDTH value,
  // so MIN_INT / -1 naturally wraps back to MIN_INT with remainder 0.
  assign w_a_neg  = i_a[WIDTH-1];
  assign w_b_neg  = i_b[WIDTH-1];
  assign w_b_zero = (i_b == '0);
  assign w_abs_a  = w_a_neg ? (~i_a + 1'b1) : i_a;
  assign w_abs_b  = w_b_neg ? (~i_b + 1'b1) : i_b;
  assign w_dvd    = (i_op == MDU_DIV) ? w_abs_a : i_a;
  // Divisor forced to 1 on divide by zero purely to keep the divider defined;
  // the result is suppressed through o_we.
  assign w_dvs    = w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1}
                  : ((i_op == MDU_DIV) ? w_abs_b : i_b);
  assign w_quo    = w_dvd / w_dvs;
  assign w_rem    = w_dvd % w_dvs;

  always_comb begin
    w_res     = w_acc;
    o_next_hi = i_hi;
    o_next_lo = i_lo;
    o_we      = 1'b0;
    case (i_op)
      MDU_MULT:  begin w_res = w_prod_s;         o_we = 1'b1; end
      MDU_MULTU: begin w_res = w_prod_u;         o_we = 1'b1; end
      MDU_MADD:  begin w_res = w_acc + w_prod_s; o_we = 1'b1; end
      MDU_MADDU: begin w_res = w_acc + w_prod_u; o_we = 1'b1; end
      MDU_MSUB:  begin w_res = w_acc - w_prod_s; o_we = 1'b1; end
      MDU_MSUBU: begin w_res = w_acc - w_prod_u; o_we = 1'b1; end
      MDU_DIV: begin
        // Quotient truncates toward zero; remainder follows the dividend.
        w_res[WIDTH-1:0]       = (w_a_neg ^ w_b_neg) ? (~w_quo + 1'b1) : w_quo;
        w_res[2*WIDTH-1:WIDTH] = w_a_neg ? (~w_rem + 1'b1) : w_rem;
        o_we                   = ~w_b_zero;
      end
      MDU_DIVU: begin
        w_res[WIDTH-1:0]       = w_quo;
        w_res[2*WIDTH-1:WIDTH] = w_rem;
        o_we                   = ~w_b_zero;
      end
      default: ;
    endcase
    o_next_hi = w_res[2*WIDTH-1:WIDTH];
    o_next_lo = w_res[WIDTH-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/e_mdu_pipe.sv
`default_nettype none
// ============================================================================
//  Module  : e_mdu_pipe
//  Purpose : Execute-stage multiply/divide unit. Owns HI/LO, runs
//            MULT/MADD/MSUB/DIV over a fixed number of busy cycles, takes
//            MTHI/MTLO in one cycle, and can be cancelled by flush.
//  Ports   : clk    rising-edge clock
//            reset  synchronous active-high reset
//            flush  cancel in-flight op, drop same-cycle start
//            start  issue MDUOp this cycle
//            MDUOp  4-bit operation code
//            A, B   rs / rt operands
//            busy   operation in flight (registered-only path)
//            HI, LO architectural HI / LO registers
//  Rev     : 1.0  initial release
// ============================================================================
module e_mdu_pipe
  import e_mdu_pipe_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = c_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = c_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             start,
  input  logic [3:0]       MDUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int c_MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);
  localparam logic [c_CNT_W-1:0] c_MULT_LAT = c_CNT_W'(MULT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_DIV_LAT  = c_CNT_W'(DIV_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_cnt;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_busy;
  logic               w_accept;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_done;
  logic [WIDTH-1:0]   w_next_hi;
  logic [WIDTH-1:0]   w_next_lo;
  logic               w_we;

  // busy depends only on the counter register, never on start/MDUOp.
  assign w_busy   = (r_cnt != '0);
  assign w_is_mul = is_mul_op(MDUOp);
  assign w_is_div = is_div_op(MDUOp);
  assign w_accept = start & ~w_busy & ~flush;
  // Completion edge is the 1->0 counter step; a coincident flush kills it.
  assign w_done   = (r_cnt == c_CNT_ONE) & ~flush;

  e_mdu_arith #(
    .WIDTH     (WIDTH)
  ) u_arith (
    .i_op      (r_op),
    .i_a       (r_a),
    .i_b       (r_b),
    .i_hi      (r_hi),
    .i_lo      (r_lo),
    .o_next_hi (w_next_hi),
    .o_next_lo (w_next_lo),
    .o_we      (w_we)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_op  <= MDU_NONE;
      r_a   <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (flush) begin
        r_cnt <= '0;
      end else if (w_accept && (w_is_mul || w_is_div)) begin
        r_cnt <= w_is_div ? c_DIV_LAT : c_MULT_LAT;
        r_op  <= MDUOp;
        r_a   <= A;
        r_b   <= B;
      end else if (w_busy) begin
        r_cnt <= r_cnt - c_CNT_ONE;
      end

      // Completion requires busy and accept requires idle, so at most one
      // of these HI/LO writers fires on any edge.
      if (w_done && w_we) begin
        r_hi <= w_next_hi;
        r_lo <= w_next_lo;
      end else if (w_accept && (MDUOp == MDU_MTHI)) begin
        r_hi <= A;
      end else if (w_accept && (MDUOp == MDU_MTLO)) begin
        r_lo <= A;
      end
    end
  end

  assign busy = w_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
`default_nettype wire
